// File: rtl/nes_input_hub.sv
// NES controller input hub: reads NUM_PADS controllers in parallel on each vblank
// rising edge and commits a debounced-free button frame with press/release edges.
// Optional feature: define NES_INPUT_HUB_SOCD_EN to clear simultaneous opposite
// directions (Up+Down, Left+Right) per pad before the frame is committed.
module nes_input_hub #(
    parameter int NUM_PADS         = 2,
    parameter int CYCLES_PER_PULSE = 125
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_vblank,
    input  logic [NUM_PADS-1:0]   i_ctrl_data,
    output logic                  o_ctrl_latch,
    output logic                  o_ctrl_clock,
    output logic                  o_busy,
    output logic                  o_valid,
    output logic [8*NUM_PADS-1:0] o_buttons,
    output logic [8*NUM_PADS-1:0] o_pressed,
    output logic [8*NUM_PADS-1:0] o_released
);

    localparam int CW = $clog2(CYCLES_PER_PULSE);
    localparam int BW = 8 * NUM_PADS;

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StClkLow,
        StClkHigh,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [BW-1:0]   sr_q, sr_d;
    logic            vblank_q;
    logic            trigger;
    logic            phase_last;
    logic            commit;
    logic [BW-1:0]   frame;

    logic [BW-1:0]   buttons_q;
    logic [BW-1:0]   pressed_q;
    logic [BW-1:0]   released_q;
    logic            valid_q;

`ifdef NES_INPUT_HUB_SOCD_EN
    // Opposite directions pressed together cancel each other out.
    function automatic logic [BW-1:0] socd_clean(input logic [BW-1:0] f);
        logic [BW-1:0] r;
        r = f;
        for (int n = 0; n < NUM_PADS; n++) begin
            if (f[8*n+4] && f[8*n+5]) begin
                r[8*n+4] = 1'b0;
                r[8*n+5] = 1'b0;
            end
            if (f[8*n+6] && f[8*n+7]) begin
                r[8*n+6] = 1'b0;
                r[8*n+7] = 1'b0;
            end
        end
        return r;
    endfunction
`endif

    assign trigger    = i_vblank && !vblank_q && (state_q == StIdle);
    assign phase_last = (cnt_q == CW'(CYCLES_PER_PULSE - 1));

    // Next-state, phase/bit counters and serial capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                bit_d = '0;
                if (trigger) state_d = StLatch;
            end
            StLatch: begin
                if (phase_last) begin
                    cnt_d   = '0;
                    state_d = StClkLow;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StClkLow: begin
                if (phase_last) begin
                    cnt_d = '0;
                    // Lines are active-low: invert so 1 = pressed.
                    for (int n = 0; n < NUM_PADS; n++) begin
                        for (int k = 0; k < 8; k++) begin
                            if (bit_q == 3'(k)) sr_d[8*n+k] = ~i_ctrl_data[n];
                        end
                    end
                    if (bit_q == 3'd7) begin
                        state_d = StDone;
                        commit  = 1'b1;
                    end else begin
                        state_d = StClkHigh;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StClkHigh: begin
                if (phase_last) begin
                    cnt_d   = '0;
                    bit_d   = bit_q + 3'd1;
                    state_d = StClkLow;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                bit_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef NES_INPUT_HUB_SOCD_EN
    assign frame = socd_clean(sr_d);
`else
    assign frame = sr_d;
`endif

    // FSM state, counters, capture register and vblank edge detector.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bit_q    <= '0;
            sr_q     <= '0;
            vblank_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sr_q     <= sr_d;
            vblank_q <= i_vblank;
        end
    end

    // Frame commit: the new frame and its edges become visible in the DONE cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            buttons_q  <= '0;
            pressed_q  <= '0;
            released_q <= '0;
            valid_q    <= 1'b0;
        end else if (commit) begin
            buttons_q  <= frame;
            pressed_q  <= frame & ~buttons_q;
            released_q <= ~frame & buttons_q;
            valid_q    <= 1'b1;
        end else begin
            pressed_q  <= '0;
            released_q <= '0;
            valid_q    <= 1'b0;
        end
    end

    assign o_ctrl_latch = (state_q == StLatch);
    assign o_ctrl_clock = (state_q == StClkHigh);
    assign o_busy       = (state_q != StIdle);
    assign o_valid      = valid_q;
    assign o_buttons    = buttons_q;
    assign o_pressed    = pressed_q;
    assign o_released   = released_q;

endmodule

// File: tb/tb_nes_input_hub.sv
// Directed bench for nes_input_hub (2 pads, 4 cycles per phase).
module tb_nes_input_hub;

    localparam int NP = 2;
    localparam int P  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vblank = 1'b0;
    logic [NP-1:0] data = '1;
    logic          latch, cclk, busy, valid;
    logic [15:0]   buttons, pressed, released;

    int tests = 0;
    int fails = 0;

    nes_input_hub #(
        .NUM_PADS         (NP),
        .CYCLES_PER_PULSE (P)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_vblank     (vblank),
        .i_ctrl_data  (data),
        .o_ctrl_latch (latch),
        .o_ctrl_clock (cclk),
        .o_busy       (busy),
        .o_valid      (valid),
        .o_buttons    (buttons),
        .o_pressed    (pressed),
        .o_released   (released)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            vblank = 1'($urandom_range(0, 1));
            data   = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
            tests++;
            if ({latch, cclk, busy, valid, buttons, pressed, released} !== '0) begin
                fails++;
                $display("FAIL reset_outputs cycle %0d: got l=%b c=%b b=%b v=%b btn=%h p=%h r=%h, want all 0",
                         i, latch, cclk, busy, valid, buttons, pressed, released);
            end
        end
        // vblank already high at release must start a read immediately.
        vblank = 1'b1;
        data   = '1;
        rst_n  = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (latch !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_trigger: got latch=%b busy=%b, want 1 1", latch, busy);
        end
        rst_n  = 1'b0;
        vblank = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tests++;
        if (latch !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_abort_idle: got latch=%b busy=%b valid=%b, want 0 0 0",
                     latch, busy, valid);
        end
        repeat (2) @(posedge clk);
    endtask

    // One read. Serial lines present bit k in cycles [2kP, 2kP+2P-1] counted from the
    // first latch cycle, so each bit is stable around its sampling cycle (2k+2)P-1.
    task automatic run_read(input string name, input logic [7:0] l0, input logic [7:0] l1,
                            input int glitch_at, input int abort_at,
                            input logic [15:0] eb, input logic [15:0] ep,
                            input logic [15:0] er);
        int          latch_err = 0, clk_err = 0, busy_err = 0, edge_err = 0;
        int          nvalid = 0, valid_at = -1;
        int          last_c = 16 * P + 8;
        logic [15:0] cb = '0, cp = '0, cr = '0;
        logic        aborted, exp_latch, exp_clk, exp_busy;
        int          k;
        @(posedge clk); #1;
        vblank = 1'b1;
        for (int c = 0; c <= last_c; c++) begin
            @(posedge clk); #1;
            aborted   = (abort_at >= 0) && (c > abort_at);
            exp_latch = !aborted && (c < P);
            exp_clk   = !aborted && (c / P >= 2) && (c / P <= 14) && ((c / P) % 2 == 0);
            exp_busy  = !aborted && (c <= 16 * P);
            if (latch !== exp_latch) latch_err++;
            if (cclk !== exp_clk) clk_err++;
            if (busy !== exp_busy) busy_err++;
            if (valid === 1'b1) begin
                nvalid++;
                valid_at = c;
                cb = buttons;
                cp = pressed;
                cr = released;
            end else if ((pressed | released) !== 16'h0) begin
                edge_err++;
            end
            if (abort_at >= 0 && c == abort_at + 1) begin
                tests++;
                if ({latch, cclk, busy, valid, buttons} !== '0) begin
                    fails++;
                    $display("FAIL %s abort_state: got l=%b c=%b b=%b v=%b btn=%h, want all 0",
                             name, latch, cclk, busy, valid, buttons);
                end
                rst_n = 1'b1;
            end
            // Stimulus for this cycle
            if (c == 2) vblank = 1'b0;
            if (glitch_at >= 0 && c == glitch_at - 1) vblank = 1'b1;
            if (glitch_at >= 0 && c == glitch_at + 10) vblank = 1'b0;
            if (c == abort_at) rst_n = 1'b0;
            k = c / (2 * P);
            if (k > 7) k = 7;
            data = {l1[k], l0[k]};
        end
        data = '1;
        tests++;
        if (latch_err != 0) begin
            fails++;
            $display("FAIL %s latch_timing: %0d wrong cycles, want 0", name, latch_err);
        end
        tests++;
        if (clk_err != 0) begin
            fails++;
            $display("FAIL %s clock_timing: %0d wrong cycles, want 0", name, clk_err);
        end
        tests++;
        if (busy_err != 0) begin
            fails++;
            $display("FAIL %s busy_timing: %0d wrong cycles, want 0", name, busy_err);
        end
        tests++;
        if (edge_err != 0) begin
            fails++;
            $display("FAIL %s edges_outside_valid: %0d cycles, want 0", name, edge_err);
        end
        tests++;
        if (nvalid != ((abort_at >= 0) ? 0 : 1)) begin
            fails++;
            $display("FAIL %s valid_count: got %0d want %0d", name, nvalid,
                     (abort_at >= 0) ? 0 : 1);
        end
        if (abort_at < 0) begin
            tests++;
            if (valid_at != 16 * P) begin
                fails++;
                $display("FAIL %s valid_cycle: got %0d want %0d", name, valid_at, 16 * P);
            end
            tests++;
            if (cb !== eb || cp !== ep || cr !== er) begin
                fails++;
                $display("FAIL %s frame: got btn=%h p=%h r=%h want btn=%h p=%h r=%h",
                         name, cb, cp, cr, eb, ep, er);
            end
        end
        tests++;
        if (buttons !== eb) begin
            fails++;
            $display("FAIL %s buttons_hold: got %h want %h", name, buttons, eb);
        end
    endtask

    task automatic test_first_frame();
        run_read("first_frame", 8'h7E, 8'hFF, -1, -1, 16'h0081, 16'h0081, 16'h0000);
    endtask

    task automatic test_repeat_frame();
        run_read("repeat_frame", 8'h7E, 8'hFF, -1, -1, 16'h0081, 16'h0000, 16'h0000);
    endtask

    task automatic test_release();
        run_read("release_all", 8'hFF, 8'hFF, -1, -1, 16'h0000, 16'h0000, 16'h0081);
    endtask

    task automatic test_back_to_back();
        run_read("vblank_ignored", 8'h7E, 8'hFF, 30, -1, 16'h0081, 16'h0081, 16'h0000);
        // Pad1 A+Start pressed, pad0 released
        run_read("after_ignore", 8'hFF, 8'hF6, -1, -1, 16'h0900, 16'h0900, 16'h0081);
    endtask

    task automatic test_reset_mid_read();
        run_read("reset_mid_read", 8'h00, 8'h00, -1, 20, 16'h0000, 16'h0000, 16'h0000);
    endtask

    task automatic test_socd();
`ifdef NES_INPUT_HUB_SOCD_EN
        run_read("socd_up_down", 8'hCF, 8'hFF, -1, -1, 16'h0000, 16'h0000, 16'h0000);
`else
        run_read("socd_up_down", 8'hCF, 8'hFF, -1, -1, 16'h0030, 16'h0030, 16'h0000);
`endif
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_repeat_frame();
        test_release();
        test_back_to_back();
        test_reset_mid_read();
        test_socd();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
